mux_n_pipe: RTL

//   Parametrised N-input, WIDTH-bit selector with a registered valid/ready output stage.

---
 rtl/mux_n_pipe.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mux_n_pipe.sv
// N-input WIDTH-bit selector feeding a registered valid/ready stage with a 2-entry skid buffer.
// Optional define MUX_SEL_CHECK_EN: out-of-range sel stores zero data and flags sel_err.
module mux_n_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [N*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_err_q, main_err_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] word_data;
    logic             word_err;
    logic             accept;
    logic             pop;

    // Unmatched sel falls through to the last channel unless checking is enabled.
    always_comb begin
        word_data = in_bus[(N-1)*WIDTH +: WIDTH];
        word_err  = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(sel) == i) word_data = in_bus[i*WIDTH +: WIDTH];
        end
`ifdef MUX_SEL_CHECK_EN
        if (32'(sel) >= N) begin
            word_data = '0;
            word_err  = 1'b1;
        end
`endif
    end

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = ONE;
                        main_data_d = word_data;
                        main_err_d  = word_err;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_data_d = word_data;
                        main_err_d  = word_err;
                    end else if (accept) begin
                        state_d     = FULL;
                        skid_data_d = word_data;
                        skid_err_d  = word_err;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_err_d  = skid_err_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign sel_err   = main_err_q & out_valid_q;

endmodule
